quadra_out_buf: RTL and testbench

Result-side flow-control stage for the quadratic evaluator. It issues `in_ready` to the argument source and tags every accepted argument with a valid bit. It delays that bit by the evaluator's fixed pipeline latency and captures the evaluator's `y` into a small FIFO when the tag emerges. Results are presented downstream on a valid/ready stream. Credit accounting guarantees a result is never dropped, whatever the downstream stall pattern.

---
 rtl/quadra_out_buf_pkg.sv | 9 +
 rtl/quadra_out_buf_fifo.sv | 55 +++++
 rtl/quadra_out_buf.sv | 69 ++++++
 tb/tb_quadra_out_buf.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/quadra_out_buf_pkg.sv
// Shared types and defaults for the quadratic evaluator's result buffer.
package quadra_out_buf_pkg;
    localparam int QB_Y_W   = 24;
    localparam int QB_LAT   = 3;
    localparam int QB_DEPTH = 8;

    typedef logic signed [QB_Y_W-1:0]    y_t;
    typedef logic [$clog2(QB_DEPTH):0]   qb_cnt_t;
endpackage

// File: rtl/quadra_out_buf_fifo.sv
// Circular result buffer: storage, pointers, occupancy count, push/pop/flush.
module qb_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign dout      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst_b && push) assert (count != (AW+1)'(DEPTH));
    end
endmodule

// File: rtl/quadra_out_buf.sv
// Credit-based result stage: tags accepted arguments, captures y after LAT cycles.
module quadra_out_buf
    import quadra_out_buf_pkg::*;
#(
    parameter int Y_W   = $bits(y_t),
    parameter int LAT   = QB_LAT,
    parameter int DEPTH = QB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [Y_W-1:0]           y_in,
    output logic                     out_valid,
    output logic [Y_W-1:0]           out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [LAT-1:0] vld_sr;
    logic [SW-1:0]  inflight;
    logic           acc;
    logic           push;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + SW'(vld_sr[k]);
        end
    end

    // Credit covers both buffered and in-flight results, so the FIFO never overruns.
    assign in_ready = ({1'b0, count} + inflight) < SW'(DEPTH);
    assign acc      = in_valid && in_ready && !flush;
    assign push     = vld_sr[LAT-1] && !flush;
    assign busy     = (|vld_sr) || (count != '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_sr <= '0;
        end else if (flush) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= acc;
            for (int k = 1; k < LAT; k++) begin
                vld_sr[k] <= vld_sr[k-1];
            end
        end
    end

    qb_fifo #(
        .W     (Y_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .din       (y_in),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (out_data),
        .count     (count)
    );
endmodule

// File: tb/tb_quadra_out_buf.sv
// Scoreboard bench for quadra_out_buf with a delay-line model of the evaluator.
module tb_quadra_out_buf;
    import quadra_out_buf_pkg::*;

    localparam int LAT   = QB_LAT;
    localparam int DEPTH = QB_DEPTH;
    localparam int Y_W   = QB_Y_W;

    logic           clk = 1'b0;
    logic           rst_b = 1'b0;
    logic           in_valid = 1'b0;
    logic           flush = 1'b0;
    logic           out_ready = 1'b0;
    logic [Y_W-1:0] x = '0;
    logic [Y_W-1:0] y_in = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [Y_W-1:0] out_data;
    qb_cnt_t        count;

    logic [Y_W-1:0] ydl [LAT];
    logic [Y_W-1:0] sb [$];
    logic [LAT-1:0] acc_hist = '0;
    int             n_tests = 0;
    int             n_fail = 0;
    logic           ov_s, busy_s, ir_s;
    qb_cnt_t        cnt_s;

    always #5 clk = ~clk;

    quadra_out_buf dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .count     (count)
    );

    function automatic logic [Y_W-1:0] y_model(input logic [Y_W-1:0] a);
        return {a[Y_W-9:0], 8'h00};
    endfunction

    function automatic int popc(input logic [LAT-1:0] v);
        int n = 0;
        for (int k = 0; k < LAT; k++) n += int'(v[k]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        int   outstanding;
        int   exp_cnt;
        logic acc;
        logic hs;
        #1;
        ov_s   = out_valid;
        busy_s = busy;
        ir_s   = in_ready;
        cnt_s  = count;
        acc    = 1'b0;
        if (rst_b) begin
            outstanding = sb.size();
            exp_cnt     = outstanding - popc(acc_hist);
            chk("count", 32'(count), 32'(exp_cnt));
            chk("out_valid", 32'(out_valid), 32'(exp_cnt != 0));
            chk("busy", 32'(busy), 32'(outstanding != 0));
            chk("in_ready", 32'(in_ready), 32'(outstanding < DEPTH));
            chk("credit", 32'(outstanding <= DEPTH), 32'(1));
            acc = in_valid && in_ready && !flush;
            hs  = out_valid && out_ready && !flush;
            if (hs) begin
                if (sb.size() == 0) chk("out_extra", 32'(out_valid), 32'(0));
                else                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
            if (acc)   sb.push_back(y_model(x));
            if (flush) sb.delete();
        end
        @(posedge clk);
        if (flush || !rst_b) acc_hist = '0;
        else                 acc_hist = (acc_hist << 1) | LAT'(acc);
        for (int k = LAT - 1; k > 0; k--) ydl[k] = ydl[k-1];
        ydl[0] = y_model(x);
        #1 y_in = ydl[LAT-1];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int nacc;
        for (int k = 0; k < LAT; k++) ydl[k] = '0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_count", 32'(count), 32'(0));
        @(negedge clk);
        idle(2);
        rst_b = 1'b1;

        // Three back-to-back accepts, ready consumer
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 3);
            x = (i < 3) ? Y_W'(i + 1) : Y_W'($urandom);
            tick();
            chk("t1_out_valid", 32'(ov_s), 32'(i >= 4 && i <= 6));
            chk("t1_busy", 32'(busy_s), 32'(i >= 1 && i <= 6));
        end

        // Stalled consumer fills the buffer exactly
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            x = Y_W'($urandom);
            tick();
            nacc += int'(ir_s);
        end
        chk("t2_accepts", 32'(nacc), 32'(DEPTH));
        chk("t2_full", 32'(cnt_s), 32'(DEPTH));
        chk("t2_ready_lo", 32'(ir_s), 32'(0));
        out_ready = 1'b1;
        x = Y_W'($urandom);
        tick();
        chk("t2_ready_still_lo", 32'(ir_s), 32'(0));
        out_ready = 1'b0;
        x = Y_W'($urandom);
        tick();
        chk("t2_credit", 32'(ir_s), 32'(1));

        // Sustained push+pop near full, exercises pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x = Y_W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        idle(DEPTH + LAT + 2);
        chk("t2_drain", 32'(cnt_s), 32'(0));

        // Push+pop at count=1 steady state
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            x = Y_W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        idle(LAT + 2);

        // Random accept/stall traffic
        for (int i = 0; i < 100; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            x = Y_W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(DEPTH + LAT + 2);
        chk("t3_drain", 32'(cnt_s), 32'(0));

        // Flush with 5 buffered, 2 in flight, acceptance attempted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin x = Y_W'($urandom); tick(); end
        in_valid = 1'b0;
        idle(LAT);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin x = Y_W'($urandom); tick(); end
        flush = 1'b1;
        x = Y_W'($urandom);
        tick();
        chk("t5_pre_count", 32'(cnt_s), 32'(5));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t5_count", 32'(cnt_s), 32'(0));
        chk("t5_out_valid", 32'(ov_s), 32'(0));
        chk("t5_busy", 32'(busy_s), 32'(0));
        idle(LAT + 2);

        // Asynchronous reset mid-burst
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin x = Y_W'($urandom); tick(); end
        out_ready = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'(0));
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_in_ready", 32'(in_ready), 32'(1));
        chk("t6_count", 32'(count), 32'(0));
        sb.delete();
        acc_hist = '0;
        in_valid = 1'b0;
        @(negedge clk);
        tick();
        rst_b     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x = Y_W'(24'h000055);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 7; i++) begin
            x = Y_W'($urandom);
            tick();
            chk("t6_latency", 32'(ov_s), 32'(i == LAT + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
